// File: rtl/mem_adapter_pkg.sv
// Shared size codes, FSM states and request-classification helpers for the
// sub-word memory adapter.
package mem_adapter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // Illegal size always errors; misalignment errors only when trapping.
    function automatic logic req_is_err(input size_e size, input logic [1:0] addr_lo,
                                        input logic trap);
        logic err;
        err = 1'b0;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = trap & addr_lo[0];
            SZ_WORD: err = trap & (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Force the low address bits onto the natural boundary of the access size.
    function automatic logic [1:0] align_lo(input size_e size, input logic [1:0] addr_lo);
        logic [1:0] lo;
        lo = addr_lo;
        case (size)
            SZ_BYTE: lo = addr_lo;
            SZ_HALF: lo = {addr_lo[1], 1'b0};
            SZ_WORD: lo = 2'b00;
            default: lo = addr_lo;
        endcase
        return lo;
    endfunction

endpackage

// File: rtl/subword_mem_adapter_lane_merge.sv
// Combinational lane logic: extracts and extends load data from a DM word,
// and merges store data into the selected byte/half lane of a DM word.
module lane_merge
    import mem_adapter_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes (little-endian).
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo_i)
            2'b00:   byte_s = word_i[7:0];
            2'b01:   byte_s = word_i[15:8];
            2'b10:   byte_s = word_i[23:16];
            2'b11:   byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
    end

    // Extend the selected lane to 32 bits for loads.
    always_comb begin
        load_data_o = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: load_data_o = {{24{signed_i & byte_s[7]}}, byte_s};
            SZ_HALF: load_data_o = {{16{signed_i & half_s[15]}}, half_s};
            SZ_WORD: load_data_o = word_i;
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Replace the selected lane(s) of the read word with store data.
    always_comb begin
        store_data_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (addr_lo_i)
                    2'b00:   store_data_o[7:0]   = wdata_i[7:0];
                    2'b01:   store_data_o[15:8]  = wdata_i[7:0];
                    2'b10:   store_data_o[23:16] = wdata_i[7:0];
                    2'b11:   store_data_o[31:24] = wdata_i[7:0];
                    default: store_data_o        = word_i;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo_i[1]) begin
                    store_data_o[31:16] = wdata_i[15:0];
                end else begin
                    store_data_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: store_data_o = wdata_i;
            default: store_data_o = word_i;
        endcase
    end

endmodule

// File: rtl/subword_mem_adapter.sv
// Load/store adapter: converts byte/half/word requests into word-only DM
// accesses, with read-modify-write for sub-word stores.
module subword_mem_adapter
    import mem_adapter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_readdata,
    output logic [31:0]       dm_writedata,
    output logic              dm_we
);

    state_e            state_q;
    logic              req_ready_q;
    logic              write_q;
    size_e             size_q;
    logic              signed_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [31:0]       dm_writedata_q;
    logic              dm_we_q;

    size_e             req_size_s;
    logic              req_err_s;
    logic [1:0]        req_lo_d;
    logic [31:0]       load_data_s;
    logic [31:0]       store_data_s;

    // Classify the incoming request and compute its aligned low address bits.
    always_comb begin
        req_size_s = size_e'(req_size);
        req_err_s  = req_is_err(req_size_s, req_addr[1:0], MISALIGN_TRAP);
        req_lo_d   = align_lo(req_size_s, req_addr[1:0]);
    end

    lane_merge u_lane_merge (
        .word_i       (dm_readdata),
        .addr_lo_i    (addr_lo_q),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_s),
        .store_data_o (store_data_s)
    );

    // Transaction FSM with request capture, DM drive and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            write_q        <= 1'b0;
            size_q         <= SZ_BYTE;
            signed_q       <= 1'b0;
            addr_lo_q      <= 2'b00;
            wdata_q        <= 32'h0000_0000;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0000_0000;
            resp_err_q     <= 1'b0;
            dm_addr_q      <= {ADDR_W{1'b0}};
            dm_writedata_q <= 32'h0000_0000;
            dm_we_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    dm_we_q      <= 1'b0;
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        write_q     <= req_write;
                        size_q      <= req_size_s;
                        signed_q    <= req_signed;
                        addr_lo_q   <= req_lo_d;
                        wdata_q     <= req_wdata;
                        if (req_err_s) begin
                            // Error: answer next cycle without touching DM.
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else begin
                            dm_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_write && (req_size_s == SZ_WORD)) begin
                                state_q        <= ST_WRITE;
                                dm_writedata_q <= req_wdata;
                                dm_we_q        <= 1'b1;
                            end else begin
                                state_q <= ST_READ;
                            end
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (write_q) begin
                        // Sub-word store: merge into the word just read.
                        state_q        <= ST_WRITE;
                        dm_writedata_q <= store_data_s;
                        dm_we_q        <= 1'b1;
                    end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data_s;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_RESP;
                    dm_we_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    dm_we_q      <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    dm_we_q      <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign dm_addr      = dm_addr_q;
    assign dm_writedata = dm_writedata_q;
    assign dm_we        = dm_we_q;

endmodule

// File: tb/tb_subword_mem_adapter.sv
// Scoreboard bench for subword_mem_adapter: byte-level reference memory,
// directed cases followed by randomized loads/stores, then a mid-store reset.
module tb_subword_mem_adapter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_readdata;
    logic [31:0] dm_writedata;
    logic        dm_we;

    subword_mem_adapter #(.ADDR_W(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_addr(dm_addr), .dm_readdata(dm_readdata),
        .dm_writedata(dm_writedata), .dm_we(dm_we)
    );

    always #5 clk = ~clk;

    // Word-organised DM model with combinational read (64 bytes).
    logic [31:0] dm_mem [16];
    assign dm_readdata = dm_mem[dm_addr[5:2]];
    always @(posedge clk) if (dm_we) dm_mem[dm_addr[5:2]] <= dm_writedata;

    // Reference memory kept as plain bytes.
    logic [7:0] ref_b [64];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwe;
        logic [31:0] wdata;
        logic [31:0] waddr;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int we_cnt = 0;
    bit mon_en = 1'b1;
    exp_t cur;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        int base;
        base = a - (a % 4);
        w = 32'h0;
        for (int i = 0; i < 4; i++) w = w | (32'(ref_b[base + i]) << (8 * i));
        return w;
    endfunction

    // Monitor: checks every DM write and every response against the scoreboard.
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (dm_we) begin
                we_cnt = we_cnt + 1;
                if (sb.size() == 0) chk("unexpected_dm_we", 32'd1, 32'd0);
                else begin
                    chk("dm_writedata", dm_writedata, sb[0].wdata);
                    chk("dm_addr_on_write", dm_addr, sb[0].waddr);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    cur = sb.pop_front();
                    chk("resp_err", {31'd0, resp_err}, {31'd0, cur.err});
                    chk("resp_rdata", resp_rdata, cur.rdata);
                    chk("resp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    chk("dm_we_pulses", 32'(we_cnt), 32'(cur.nwe));
                end
                we_cnt = 0;
            end
        end
    end

    // Apply one request to the reference model and return the expected response.
    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                   input int a, input logic [31:0] wd);
        exp_t e;
        int nb;
        longint lv;
        e.rdata = 32'h0; e.wdata = 32'h0; e.nwe = 0; e.acc = 0;
        e.waddr = 32'(a - (a % 4));
        nb = (sz == 2'b11) ? 0 : (1 << sz);
        e.err = (nb == 0) || ((a % nb) != 0);
        if (e.err) begin
            e.lat = 1;
        end else if (!wr) begin
            lv = 0;
            for (int i = 0; i < nb; i++) lv = lv + (longint'(ref_b[a + i]) << (8 * i));
            if (sg && nb < 4 && lv >= (longint'(1) << (8 * nb - 1))) lv = lv - (longint'(1) << (8 * nb));
            e.rdata = lv[31:0];
            e.lat = 2;
        end else begin
            for (int i = 0; i < nb; i++) ref_b[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
            e.wdata = ref_word(a);
            e.nwe = 1;
            e.lat = (nb == 4) ? 2 : 3;
        end
        return e;
    endfunction

    // Driver: waits (bounded) for ready, issuing junk req_valid while busy.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input int a, input logic [31:0] wd);
        exp_t e;
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr = 32'($urandom_range(0, 63));
            req_write = 1'($urandom_range(0, 1));
            req_size = 2'($urandom_range(0, 3));
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = model(wr, sz, sg, a, wd);
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = 32'(a); req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dm_mem[i] = $urandom;
        dm_mem[2] = 32'h0000_0002;
        dm_mem[3] = 32'h8877_A0FF;
        for (int i = 0; i < 64; i++) ref_b[i] = 8'(dm_mem[i / 4] >> (8 * (i % 4)));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_writedata", dm_writedata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 2'b10, 1'b0, 8, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 12, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 13, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 14, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 8, 32'd42);
        issue(1'b0, 2'b10, 1'b0, 8, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 13, 32'h0000_0055);
        issue(1'b0, 2'b01, 1'b0, 9, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 4, 32'h0);
        issue(1'b1, 2'b11, 1'b0, 0, 32'h1234);
        chk("dm_word12_after_sb", ref_word(12), 32'h8877_55FF);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 63)), $urandom);
        end

        // Drain scoreboard (bounded)
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during the WRITE of a sub-word store
        begin
            int n;
            exp_t e;
            mon_en = 1'b0;
            n = 0;
            while (!req_ready && n < 20) begin @(negedge clk); n++; end
            e = model(1'b1, 2'b00, 1'b0, 21, 32'h0000_00C3);
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
            req_addr = 32'd21; req_wdata = 32'h0000_00C3;
            @(negedge clk);
            req_valid = 1'b0;
            n = 0;
            while (!dm_we && n < 5) begin @(negedge clk); n++; end
            chk("rst_test_we_seen", {31'd0, dm_we}, 32'd1);
            chk("rst_test_wdata", dm_writedata, e.wdata);
            reset = 1'b1;
            @(negedge clk);
            chk("midrst_dm_we", {31'd0, dm_we}, 32'd0);
            chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
            reset = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
            end
            mon_en = 1'b1;
        end

        // Final DM contents against the reference bytes
        for (int i = 0; i < 16; i++) chk("dm_final", dm_mem[i], ref_word(4 * i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
